// File: rtl/nes_pkg.sv
// Shared definitions for the NES pad reader: button indices, sequencer states
// and the reset-combo decode.
package nes_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [7:0] DEFAULT_REPEAT_MASK =
        (8'h01 << BTN_RIGHT) | (8'h01 << BTN_LEFT) | (8'h01 << BTN_DOWN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } nes_state_t;

    function automatic logic is_reset_combo(input logic [7:0] btn);
        return btn[BTN_START] & btn[BTN_SELECT];
    endfunction

endpackage

// File: rtl/nes_autorepeat.sv
// Per-pad held-state register plus press-edge and delayed auto-repeat event
// generation, advanced once per completed frame.
module nes_autorepeat
    import nes_pkg::*;
#(
    parameter int         DAS_FRAMES  = 10,
    parameter int         ARR_FRAMES  = 3,
    parameter logic [7:0] REPEAT_MASK = DEFAULT_REPEAT_MASK
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame,
    input  logic [7:0] i_new,
    output logic [7:0] o_held,
    output logic [7:0] o_event
);

    localparam int CW = $clog2(DAS_FRAMES + 1);
    localparam logic [CW-1:0] DAS_C    = CW'(DAS_FRAMES);
    localparam logic [CW-1:0] RELOAD_C = CW'(DAS_FRAMES - ARR_FRAMES);

    logic [7:0]         r_held;
    logic [7:0]         r_event;
    logic [7:0][CW-1:0] r_cnt;
    logic [7:0][CW-1:0] w_cnt_nxt;
    logic [7:0]         w_event_nxt;

    // Next repeat-counter value and event bit for every button
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_event_nxt = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (!i_new[b]) begin
                w_cnt_nxt[b]   = {CW{1'b0}};
                w_event_nxt[b] = 1'b0;
            end else if (!r_held[b]) begin
                w_cnt_nxt[b]   = {CW{1'b0}};
                w_event_nxt[b] = 1'b1;
            end else if (REPEAT_MASK[b]) begin
                // The counter never passes DAS: hitting it fires and reloads.
                if (r_cnt[b] + CW'(1) == DAS_C) begin
                    w_cnt_nxt[b]   = RELOAD_C;
                    w_event_nxt[b] = 1'b1;
                end else begin
                    w_cnt_nxt[b]   = r_cnt[b] + CW'(1);
                    w_event_nxt[b] = 1'b0;
                end
            end else begin
                w_cnt_nxt[b]   = r_cnt[b];
                w_event_nxt[b] = 1'b0;
            end
        end
    end

    // Commit held state and counters on the frame strobe; events last one cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_held  <= 8'h00;
            r_event <= 8'h00;
            r_cnt   <= {(8*CW){1'b0}};
        end else if (i_frame) begin
            r_held  <= i_new;
            r_event <= w_event_nxt;
            r_cnt   <= w_cnt_nxt;
        end else begin
            r_event <= 8'h00;
        end
    end

    assign o_held  = r_held;
    assign o_event = r_event;

endmodule

// File: rtl/nes_pad_reader.sv
// Polls NUM_PADS NES controllers over a shared latch/clock pair, deserialises
// eight buttons per pad and raises a Start+Select hold-to-reset pulse on pad 0.
module nes_pad_reader
    import nes_pkg::*;
#(
    parameter int         NUM_PADS     = 2,
    parameter int         POLL_DIV     = 833333,
    parameter int         LATCH_CYCLES = 600,
    parameter int         HALF_CYCLES  = 300,
    parameter int         DAS_FRAMES   = 10,
    parameter int         ARR_FRAMES   = 3,
    parameter logic [7:0] REPEAT_MASK  = DEFAULT_REPEAT_MASK,
    parameter int         RESET_FRAMES = 120
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_PADS-1:0]   i_nes_data,
    output logic                  o_nes_latch,
    output logic                  o_nes_clk,
    output logic [8*NUM_PADS-1:0] o_buttons_held,
    output logic [8*NUM_PADS-1:0] o_button_event,
    output logic                  o_frame_valid,
    output logic                  o_nes_reset
);

    localparam int PW   = $clog2(POLL_DIV);
    localparam int CNTW = $clog2(LATCH_CYCLES + HALF_CYCLES + 1);
    localparam int RW   = $clog2(RESET_FRAMES + 1);
    localparam logic [PW-1:0]   POLL_LAST  = PW'(POLL_DIV - 1);
    localparam logic [CNTW-1:0] LATCH_LAST = CNTW'(LATCH_CYCLES - 1);
    localparam logic [CNTW-1:0] HALF_LAST  = CNTW'(HALF_CYCLES - 1);
    localparam logic [RW-1:0]   RESET_C    = RW'(RESET_FRAMES);

    nes_state_t                r_state;
    logic [PW-1:0]             r_poll;
    logic [CNTW-1:0]           r_phase;
    logic [2:0]                r_bit;
    logic                      r_latch;
    logic                      r_nclk;
    logic                      r_frame_valid;
    logic [NUM_PADS-1:0][7:0]  r_shift;
    logic [RW-1:0]             r_combo_cnt;
    logic                      r_armed;
    logic                      r_nes_reset;

    logic                      w_poll_wrap;
    logic                      w_frame_end;
    logic [RW-1:0]             w_combo_inc;

    assign w_poll_wrap = (r_poll == POLL_LAST);
    assign w_frame_end = (r_state == HIGH) && (r_phase == HALF_LAST) && (r_bit == 3'd7);
    assign w_combo_inc = (r_combo_cnt == RESET_C) ? r_combo_cnt : r_combo_cnt + RW'(1);

    // Free-running poll divider
    always_ff @(posedge i_clk) begin
        if (i_reset || w_poll_wrap) begin
            r_poll <= {PW{1'b0}};
        end else begin
            r_poll <= r_poll + PW'(1);
        end
    end

    // Frame sequencer: latch strobe, eight clock pulses, then one DONE cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_phase       <= {CNTW{1'b0}};
            r_bit         <= 3'd0;
            r_latch       <= 1'b0;
            r_nclk        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_shift       <= {(8*NUM_PADS){1'b0}};
        end else begin
            r_frame_valid <= w_frame_end;
            case (r_state)
                IDLE: begin
                    r_phase <= {CNTW{1'b0}};
                    r_bit   <= 3'd0;
                    if (w_poll_wrap) begin
                        r_state <= LATCH;
                        r_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (r_phase == LATCH_LAST) begin
                        r_state <= LOW;
                        r_latch <= 1'b0;
                        r_phase <= {CNTW{1'b0}};
                    end else begin
                        r_phase <= r_phase + CNTW'(1);
                    end
                end
                LOW: begin
                    // Data is stable by the end of the low half; capture it then.
                    if (r_phase == HALF_LAST) begin
                        for (int p = 0; p < NUM_PADS; p++) begin
                            r_shift[p][r_bit] <= ~i_nes_data[p];
                        end
                        r_state <= HIGH;
                        r_nclk  <= 1'b1;
                        r_phase <= {CNTW{1'b0}};
                    end else begin
                        r_phase <= r_phase + CNTW'(1);
                    end
                end
                HIGH: begin
                    if (r_phase == HALF_LAST) begin
                        r_nclk  <= 1'b0;
                        r_phase <= {CNTW{1'b0}};
                        if (r_bit == 3'd7) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= LOW;
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_phase <= r_phase + CNTW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_latch <= 1'b0;
                    r_nclk  <= 1'b0;
                end
            endcase
        end
    end

    // Start+Select hold detector on pad 0; fires once per continuous hold
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_combo_cnt <= {RW{1'b0}};
            r_armed     <= 1'b1;
            r_nes_reset <= 1'b0;
        end else if (w_frame_end) begin
            if (is_reset_combo(r_shift[0])) begin
                r_combo_cnt <= w_combo_inc;
                if (r_armed && (w_combo_inc == RESET_C)) begin
                    r_nes_reset <= 1'b1;
                    r_armed     <= 1'b0;
                end else begin
                    r_nes_reset <= 1'b0;
                end
            end else begin
                r_combo_cnt <= {RW{1'b0}};
                r_armed     <= 1'b1;
                r_nes_reset <= 1'b0;
            end
        end else begin
            r_nes_reset <= 1'b0;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        nes_autorepeat #(
            .DAS_FRAMES  (DAS_FRAMES),
            .ARR_FRAMES  (ARR_FRAMES),
            .REPEAT_MASK (REPEAT_MASK)
        ) u_autorepeat (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_frame (w_frame_end),
            .i_new   (r_shift[p]),
            .o_held  (o_buttons_held[8*p +: 8]),
            .o_event (o_button_event[8*p +: 8])
        );
    end

    assign o_nes_latch   = r_latch;
    assign o_nes_clk     = r_nclk;
    assign o_frame_valid = r_frame_valid;
    assign o_nes_reset   = r_nes_reset;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader: emulated controllers on the serial
// lines and a hold-duration reference model for events and the reset combo.
module tb_nes_pad_reader;
    import nes_pkg::*;

    localparam int         NP  = 2;
    localparam int         PD  = 200;
    localparam int         LC  = 4;
    localparam int         HC  = 2;
    localparam int         DAS = 3;
    localparam int         ARR = 2;
    localparam int         RF  = 4;
    localparam logic [7:0] RM  = 8'hE0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  nes_data;
    logic        nes_latch, nes_clk, frame_valid, nes_reset;
    logic [15:0] held_o, event_o;

    logic [7:0]  pad_btn [NP];
    logic [7:0]  pad_sh  [NP];
    logic        pad_prev_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_cnt [NP][8];
    int combo_run;

    nes_pad_reader #(
        .NUM_PADS(NP), .POLL_DIV(PD), .LATCH_CYCLES(LC), .HALF_CYCLES(HC),
        .DAS_FRAMES(DAS), .ARR_FRAMES(ARR), .REPEAT_MASK(RM), .RESET_FRAMES(RF)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_nes_data(nes_data),
        .o_nes_latch(nes_latch), .o_nes_clk(nes_clk),
        .o_buttons_held(held_o), .o_button_event(event_o),
        .o_frame_valid(frame_valid), .o_nes_reset(nes_reset)
    );

    always #5 clk = ~clk;

    // Controller emulation: parallel load while latched, shift on clock rise
    always @(posedge clk) begin
        pad_prev_clk <= nes_clk;
        for (int p = 0; p < NP; p++) begin
            if (nes_latch) pad_sh[p] <= pad_btn[p];
            else if (nes_clk && !pad_prev_clk) pad_sh[p] <= {1'b0, pad_sh[p][7:1]};
        end
    end
    assign nes_data = {~pad_sh[1][0], ~pad_sh[0][0]};

    task automatic model_reset();
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 8; b++) hold_cnt[p][b] = 0;
        combo_run = 0;
    endtask

    // Expected events from how many consecutive frames each button has been held
    task automatic model_step(input logic [7:0] b0, input logic [7:0] b1,
                              output logic [15:0] ev, output logic rs);
        logic [7:0] bb [NP];
        logic [7:0] mask;
        int h;
        mask = RM;
        bb[0] = b0; bb[1] = b1; ev = 16'h0000;
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 8; b++) begin
                if (bb[p][b]) begin
                    hold_cnt[p][b]++;
                    h = hold_cnt[p][b];
                    if (h == 1) ev[8*p+b] = 1'b1;
                    else if (mask[b] && h > DAS && ((h - 1 - DAS) % ARR) == 0) ev[8*p+b] = 1'b1;
                end else begin
                    hold_cnt[p][b] = 0;
                end
            end
        end
        combo_run = (b0[BTN_START] && b0[BTN_SELECT]) ? combo_run + 1 : 0;
        rs = (combo_run == RF);
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                             output logic [15:0] held, output logic [15:0] ev,
                             output logic rs, output logic quiet, output logic ok);
        pad_btn[0] = b0; pad_btn[1] = b1; ok = 1'b0;
        for (int i = 0; i < 2*PD; i++) begin
            @(negedge clk);
            if (frame_valid) begin ok = 1'b1; break; end
        end
        held = held_o; ev = event_o; rs = nes_reset;
        @(negedge clk);
        quiet = !frame_valid && (event_o == 16'h0000) && !nes_reset && (held_o == held);
    endtask

    task automatic test_reset();
        rst = 1'b1; pad_btn[0] = 8'h00; pad_btn[1] = 8'h00; model_reset();
        repeat (4) @(negedge clk);
        n_checks++;
        if ({nes_latch, nes_clk, frame_valid, nes_reset} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {nes_latch, nes_clk, frame_valid, nes_reset});
        end
        n_checks++;
        if ({held_o, event_o} !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {held_o, event_o});
        end
    endtask

    task automatic test_first_frame();
        int cyc, lat_hi, pulses, fv_at;
        logic prev;
        logic [15:0] eev;
        logic ers;
        pad_btn[0] = 8'h01 << BTN_A;
        pad_btn[1] = 8'h01 << BTN_RIGHT;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2*PD; i++) begin
            @(negedge clk); cyc++;
            if (nes_latch) break;
        end
        n_checks++;
        if (cyc != PD) begin n_fail++; $display("FAIL first_latch_delay: got %0d want %0d", cyc, PD); end
        lat_hi = 1; pulses = 0; fv_at = 1; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); fv_at++;
            if (nes_latch) lat_hi++;
            if (nes_clk && !prev) pulses++;
            prev = nes_clk;
            if (frame_valid) break;
        end
        n_checks++;
        if (lat_hi != LC) begin n_fail++; $display("FAIL latch_width: got %0d want %0d", lat_hi, LC); end
        n_checks++;
        if (pulses != 8) begin n_fail++; $display("FAIL clk_pulses: got %0d want 8", pulses); end
        n_checks++;
        if (fv_at != 37) begin n_fail++; $display("FAIL frame_valid_cycle: got %0d want 37", fv_at); end
        model_step(pad_btn[0], pad_btn[1], eev, ers);
        n_checks++;
        if (held_o !== 16'h8001) begin n_fail++; $display("FAIL first_held: got %h want 8001", held_o); end
        n_checks++;
        if (event_o !== 16'h8001 || eev !== 16'h8001) begin
            n_fail++; $display("FAIL first_event: got %h want 8001", event_o);
        end
        @(negedge clk);
        n_checks++;
        if (event_o !== 16'h0000 || frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_pulse_width: event %h fv %b want 0000 0", event_o, frame_valid);
        end
    endtask

    task automatic test_autorepeat();
        logic [15:0] held, ev, eev;
        logic rs, ers, quiet, ok;
        logic [7:0] b0;
        for (int f = 1; f <= 16; f++) begin
            b0 = (f <= 8) ? (8'h01 << BTN_LEFT) : (8'h01 << BTN_A);
            run_frame(b0, 8'h00, held, ev, rs, quiet, ok);
            model_step(b0, 8'h00, eev, ers);
            n_checks++;
            if (!ok || held !== {8'h00, b0}) begin n_fail++; $display("FAIL rep_held f%0d: got %h want %h", f, held, {8'h00, b0}); end
            n_checks++;
            if (ev !== eev) begin n_fail++; $display("FAIL rep_event f%0d: got %h want %h", f, ev, eev); end
            n_checks++;
            if (f <= 8 && ev[BTN_LEFT] !== (f == 1 || f == 4 || f == 6 || f == 8)) begin
                n_fail++; $display("FAIL rep_left f%0d: got %b", f, ev[BTN_LEFT]);
            end else if (f > 8 && ev[BTN_A] !== (f == 9)) begin
                n_fail++; $display("FAIL rep_a f%0d: got %b want %b", f, ev[BTN_A], f == 9);
            end
            n_checks++;
            if (quiet !== 1'b1) begin n_fail++; $display("FAIL rep_quiet f%0d: got %b want 1", f, quiet); end
        end
    endtask

    task automatic test_reset_combo();
        logic [15:0] held, ev, eev;
        logic rs, ers, quiet, ok, want;
        logic [7:0] combo, b0;
        combo = (8'h01 << BTN_START) | (8'h01 << BTN_SELECT);
        for (int f = 1; f <= 15; f++) begin
            b0 = (f == 11) ? (8'h01 << BTN_START) : combo;
            want = (f == 4) || (f == 15);
            run_frame(b0, 8'h00, held, ev, rs, quiet, ok);
            model_step(b0, 8'h00, eev, ers);
            n_checks++;
            if (!ok || rs !== want || ers !== want) begin
                n_fail++; $display("FAIL combo_reset f%0d: got %b want %b", f, rs, want);
            end
            n_checks++;
            if (ev !== eev || held !== {8'h00, b0}) begin
                n_fail++; $display("FAIL combo_event f%0d: got %h/%h want %h/%h", f, ev, held, eev, {8'h00, b0});
            end
            n_checks++;
            if (quiet !== 1'b1) begin n_fail++; $display("FAIL combo_quiet f%0d: got %b want 1", f, quiet); end
        end
    endtask

    task automatic test_pad1_combo();
        logic [15:0] held, ev, eev;
        logic rs, ers, quiet, ok;
        logic [7:0] combo;
        combo = (8'h01 << BTN_START) | (8'h01 << BTN_SELECT);
        for (int f = 1; f <= 10; f++) begin
            run_frame(8'h00, combo, held, ev, rs, quiet, ok);
            model_step(8'h00, combo, eev, ers);
            n_checks++;
            if (!ok || rs !== 1'b0) begin n_fail++; $display("FAIL pad1_reset f%0d: got %b want 0", f, rs); end
            n_checks++;
            if (ev !== eev || held !== {combo, 8'h00}) begin
                n_fail++; $display("FAIL pad1_event f%0d: got %h/%h want %h/%h", f, ev, held, eev, {combo, 8'h00});
            end
            n_checks++;
            if (quiet !== 1'b1) begin n_fail++; $display("FAIL pad1_quiet f%0d: got %b want 1", f, quiet); end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] held, ev, eev;
        logic rs, ers, quiet, ok, prev;
        int cnt, cyc;
        pad_btn[0] = 8'h01 << BTN_B;
        pad_btn[1] = 8'h01 << BTN_UP;
        cnt = 0; prev = 1'b0;
        for (int i = 0; i < 2*PD; i++) begin
            @(negedge clk);
            if (nes_clk && !prev) cnt++;
            prev = nes_clk;
            if (cnt == 3) break;
        end
        n_checks++;
        if (cnt != 3) begin n_fail++; $display("FAIL mid_find_pulse: got %0d want 3", cnt); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({nes_latch, nes_clk, frame_valid, nes_reset, held_o, event_o} !== 36'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", {nes_latch, nes_clk, frame_valid, nes_reset, held_o, event_o});
        end
        rst = 1'b0;
        model_reset();
        cyc = 0;
        for (int i = 0; i < 2*PD; i++) begin
            @(negedge clk); cyc++;
            if (nes_latch) break;
        end
        n_checks++;
        if (cyc != PD) begin n_fail++; $display("FAIL mid_restart_delay: got %0d want %0d", cyc, PD); end
        run_frame(pad_btn[0], pad_btn[1], held, ev, rs, quiet, ok);
        model_step(pad_btn[0], pad_btn[1], eev, ers);
        n_checks++;
        if (!ok || held !== {pad_btn[1], pad_btn[0]} || ev !== eev) begin
            n_fail++; $display("FAIL mid_after_frame: got %h/%h want %h/%h", held, ev, {pad_btn[1], pad_btn[0]}, eev);
        end
    endtask

    task automatic test_alternate();
        logic [15:0] held, ev, eev;
        logic rs, ers, quiet, ok, on;
        logic [7:0] b0;
        for (int f = 1; f <= 8; f++) begin
            on = (f % 2) == 1;
            b0 = on ? (8'h01 << BTN_DOWN) : 8'h00;
            run_frame(b0, 8'h00, held, ev, rs, quiet, ok);
            model_step(b0, 8'h00, eev, ers);
            n_checks++;
            if (!ok || held[BTN_DOWN] !== on) begin n_fail++; $display("FAIL alt_held f%0d: got %b want %b", f, held[BTN_DOWN], on); end
            n_checks++;
            if (ev[BTN_DOWN] !== on || ev !== eev) begin
                n_fail++; $display("FAIL alt_event f%0d: got %h want %h", f, ev, eev);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] held, ev, eev;
        logic rs, ers, quiet, ok;
        logic [7:0] b0, b1;
        b0 = 8'h00; b1 = 8'h00;
        for (int f = 1; f <= 30; f++) begin
            if ($urandom_range(0, 3) == 0) b0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b1 = 8'($urandom);
            run_frame(b0, b1, held, ev, rs, quiet, ok);
            model_step(b0, b1, eev, ers);
            n_checks++;
            if (!ok || held !== {b1, b0}) begin n_fail++; $display("FAIL rnd_held f%0d: got %h want %h", f, held, {b1, b0}); end
            n_checks++;
            if (ev !== eev) begin n_fail++; $display("FAIL rnd_event f%0d: got %h want %h", f, ev, eev); end
            n_checks++;
            if (rs !== ers) begin n_fail++; $display("FAIL rnd_reset f%0d: got %b want %b", f, rs, ers); end
            n_checks++;
            if (quiet !== 1'b1) begin n_fail++; $display("FAIL rnd_quiet f%0d: got %b want 1", f, quiet); end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_autorepeat();
        test_reset_combo();
        test_pad1_combo();
        test_mid_reset();
        test_alternate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
